// File: rtl/multicycle_datapath.sv
// multicycle_datapath
//   Multicycle processor datapath with a single shared memory port. Each
//   instruction walks FETCH -> DECODE -> EXECUTE -> (MEMORY) -> (WRITEBACK)
//   and then returns to FETCH. A HALT instruction parks the FSM until reset.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   reset      : synchronous, active-high reset
//   mem_req    : memory request valid (FETCH and MEMORY only)
//   mem_we     : request is a store
//   mem_addr   : byte address (0 when idle)
//   mem_wdata  : store data (0 when idle)
//   mem_ready  : memory accepts/completes the request this cycle
//   mem_rdata  : read data, valid with mem_ready on a read
//   pc         : current program counter
//   state      : current FSM state encoding
//   halted     : high while in HALT
module multicycle_datapath #(
  parameter int            N        = 32,
  parameter int            R        = 7,
  parameter logic [N-1:0]  RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic         mem_ready,
  input  logic [N-1:0] mem_rdata,
  output logic [N-1:0] pc,
  output logic [2:0]   state,
  output logic         halted
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  localparam logic [4:0] OP_RTYPE = 5'd0;
  localparam logic [4:0] OP_ADDI  = 5'd1;
  localparam logic [4:0] OP_LW    = 5'd2;
  localparam logic [4:0] OP_SW    = 5'd3;
  localparam logic [4:0] OP_BEQ   = 5'd4;
  localparam logic [4:0] OP_J     = 5'd5;
  localparam logic [4:0] OP_HALT  = 5'd31;

  state_t         state_q;
  logic [N-1:0]   pc_q;
  logic [N-1:0]   instr_q;
  logic [N-1:0]   a_q;
  logic [N-1:0]   b_q;
  logic [N-1:0]   alu_out_q;
  logic [N-1:0]   mdr_q;
  logic [N-1:0]   regs [2**R];

  // Instruction fields, always taken from the latched instruction.
  logic [4:0]     op;
  logic [R-1:0]   rs;
  logic [R-1:0]   rt;
  logic [R-1:0]   rd;
  logic [3:0]     funct;
  logic [N-1:0]   imm_ext;
  logic [26:0]    jaddr;

  assign op      = instr_q[31:27];
  assign rs      = instr_q[20+R-1:20];
  assign rt      = instr_q[13+R-1:13];
  assign rd      = instr_q[6+R-1:6];
  assign funct   = instr_q[3:0];
  assign imm_ext = {{(N-13){instr_q[12]}}, instr_q[12:0]};
  assign jaddr   = instr_q[26:0];

  // Register 0 is hard-wired to zero on the read side.
  logic [N-1:0] rd_a;
  logic [N-1:0] rd_b;
  assign rd_a = (rs == '0) ? '0 : regs[rs];
  assign rd_b = (rt == '0) ? '0 : regs[rt];

  function automatic logic [N-1:0] alu(input logic [3:0] f,
                                       input logic [N-1:0] x,
                                       input logic [N-1:0] y);
    case (f)
      4'd0:    return x & y;
      4'd1:    return x | y;
      4'd2:    return x + y;
      4'd6:    return x - y;
      4'd7:    return {{(N-1){1'b0}}, ($signed(x) < $signed(y))};
      default: return '0;
    endcase
  endfunction

  // RTYPE uses the funct-selected ALU; ADDI/LW/SW all compute A + imm.
  logic [N-1:0] alu_res;
  assign alu_res = (op == OP_RTYPE) ? alu(funct, a_q, b_q) : (a_q + imm_ext);

  // Writeback destination/data selection.
  logic [R-1:0] wb_idx;
  logic [N-1:0] wb_data;
  logic         wb_en;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    wb_idx  = rt;
    wb_data = alu_out_q;
    if (op == OP_RTYPE) begin
      wb_idx = rd;
    end else if (op == OP_LW) begin
      wb_data = mdr_q;
    end
  end

  // Writes to register 0 are dropped so it always reads back as zero.
  assign wb_en = (state_q == S_WRITEBACK) && (wb_idx != '0);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      mdr_q     <= '0;
      // NOTE: the register file must come out of reset all-zero, so it is
      // built from resettable flops rather than an inferred RAM.
      for (int i = 0; i < 2**R; i++) begin
        regs[i] <= '0;
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          if (mem_ready) begin
            instr_q <= mem_rdata;
            pc_q    <= pc_q + N'(4);
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_q     <= rd_a;
          b_q     <= rd_b;
          state_q <= (op == OP_HALT) ? S_HALT : S_EXECUTE;
        end
        S_EXECUTE: begin
          case (op)
            OP_RTYPE, OP_ADDI: begin
              alu_out_q <= alu_res;
              state_q   <= S_WRITEBACK;
            end
            OP_LW, OP_SW: begin
              alu_out_q <= alu_res;
              state_q   <= S_MEMORY;
            end
            OP_BEQ: begin
              // pc already points past the branch, so the offset is
              // relative to the following instruction.
              if (a_q == b_q) pc_q <= pc_q + (imm_ext << 2);
              state_q <= S_FETCH;
            end
            OP_J: begin
              pc_q    <= {pc_q[N-1:29], jaddr, 2'b00};
              state_q <= S_FETCH;
            end
            default: state_q <= S_FETCH;
          endcase
        end
        S_MEMORY: begin
          if (mem_ready) begin
            if (op == OP_LW) begin
              mdr_q   <= mem_rdata;
              state_q <= S_WRITEBACK;
            end else begin
              state_q <= S_FETCH;
            end
          end
        end
        S_WRITEBACK: begin
          if (wb_en) regs[wb_idx] <= wb_data;
          state_q <= S_FETCH;
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // Memory interface is decoded from registered state only, so it stays
  // stable for the whole time a request waits on mem_ready. Gating with
  // reset drops an in-flight request in the very cycle reset is raised.
  logic in_mem;
  assign in_mem    = (state_q == S_MEMORY);
  assign mem_req   = !reset && ((state_q == S_FETCH) || in_mem);
  assign mem_we    = mem_req && in_mem && (op == OP_SW);
  assign mem_addr  = !mem_req ? '0 : (in_mem ? alu_out_q : pc_q);
  assign mem_wdata = (mem_req && in_mem) ? b_q : '0;

  assign pc     = pc_q;
  assign state  = state_q;
  assign halted = (state_q == S_HALT);

endmodule

// File: doc/multicycle_datapath.md
MULTICYCLE_DATAPATH -- requirements
Module: multicycle_datapath

Interface
REQ-001 SHALL have parameter N, default 32: data/address width; legal values are N >= 32.
REQ-002 SHALL have parameter R, default 7: register index width, 1..7; the register file holds 2**R words.
REQ-003 SHALL have parameter RESET_PC, default 0: PC value loaded on reset.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port mem_req, output, 1 bit: memory request valid.
REQ-007 SHALL have port mem_we, output, 1 bit: request is a write.
REQ-008 SHALL have port mem_addr, output, N bits: byte address.
REQ-009 SHALL have port mem_wdata, output, N bits: store data.
REQ-010 SHALL have port mem_ready, input, 1 bit: memory accepts/completes the request this cycle.
REQ-011 SHALL have port mem_rdata, input, N bits: read data, valid when mem_ready=1 on a read.
REQ-012 SHALL have port pc, output, N bits: current program counter.
REQ-013 SHALL have port state, output, 3 bits: current FSM state encoding.
REQ-014 SHALL have port halted, output, 1 bit: high while in HALT.

Function
REQ-015 SHALL decode fields as op=instr[31:27], rs=instr[20+R-1:20], rt=instr[13+R-1:13], rd=instr[6+R-1:6], funct=instr[3:0], imm=instr[12:0] sign-extended to N, jaddr=instr[26:0].
REQ-016 SHALL support op 0 RTYPE (rd<=rs ALU rt, using funct), 1 ADDI, 2 LW (rt<=M[rs+imm]), 3 SW, 4 BEQ, 5 J, 31 HALT; any other op SHALL be treated as a NOP.
REQ-017 SHALL use ALU codes 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT (signed); other codes SHALL produce 0; ADD/SUB SHALL wrap modulo 2**N.
REQ-018 SHALL read register 0 as 0 and SHALL discard writes to register 0.
REQ-019 SHALL implement FSM states FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, HALT=5.
REQ-020 In FETCH, SHALL drive mem_req=1, mem_we=0, mem_addr=pc; on mem_ready it SHALL latch instr, set pc<=pc+4, and go to DECODE; otherwise it SHALL hold all request outputs stable.
REQ-021 In DECODE, SHALL latch A=reg[rs] and B=reg[rt]; it SHALL go to HALT if op=HALT, otherwise to EXECUTE.
REQ-022 In EXECUTE: RTYPE/ADDI/LW/SW SHALL latch ALUOut; BEQ SHALL set pc<=pc+(imm<<2) when A==B and go to FETCH; J SHALL set pc<={pc[N-1:29], jaddr, 2'b00} and go to FETCH; NOP SHALL go to FETCH; LW/SW SHALL go to MEMORY; RTYPE/ADDI SHALL go to WRITEBACK.
REQ-023 In MEMORY, SHALL hold mem_req=1, mem_addr=ALUOut, mem_we=(op==SW), mem_wdata=B stable until mem_ready; on ready, SW SHALL go to FETCH and LW SHALL latch mem_rdata and go to WRITEBACK.
REQ-024 In WRITEBACK, SHALL write ALUOut (RTYPE to rd, ADDI to rt) or loaded data (LW to rt), then go to FETCH.
REQ-025 SHALL produce zero-wait latencies of RTYPE/ADDI 4 cycles, LW 5, SW 4, BEQ/J/NOP 3 (FETCH to next FETCH).
REQ-026 SHALL hold mem_req=0 in DECODE, EXECUTE, WRITEBACK, and HALT; mem_ready SHALL be ignored when mem_req=0.
REQ-027 SHALL remain in HALT until reset.
REQ-028 SHALL drive mem_addr=0 and mem_wdata=0 whenever mem_req=0.

Reset
REQ-029 While reset=1 at a rising edge, SHALL set state=FETCH, pc=RESET_PC, instr=0, A=B=ALUOut=0, and all registers to 0.
REQ-030 Reset SHALL take priority over any in-flight access, including a pending mem_ready, which SHALL be discarded; mem_req SHALL be 0 in the cycle that reset is asserted and SHALL reassert in FETCH in the cycle after reset deasserts.

Verification
REQ-031 Reset, mem_ready tied to 1, ADDI r1,r0,5 at addr 0 -> pc=4 after FETCH; r1=5 after 4 cycles; next fetch at mem_addr=4.
REQ-032 Setup r1=5, r2=-3; issue RTYPE funct=7 rd=r3, rs=r2, rt=r1 -> r3=1; then issue SUB rs=r0, rt=r1 -> destination = 0xFFFFFFFB.
REQ-033 SW r1 to [r0+8] with mem_ready low for 3 cycles -> mem_req, mem_we=1, mem_addr=8, mem_wdata=5 stable for 4 cycles; FETCH follows.
REQ-034 BEQ r0,r0,imm=-1 at pc=0x10 -> next fetch at 0x10; J with jaddr=0x40 -> next fetch at 0x100.
REQ-035 Assert reset during MEMORY of an LW with mem_ready=1 in the same cycle -> destination register unchanged (0); state=FETCH; pc=RESET_PC.
REQ-036 HALT instruction -> halted=1, mem_req=0 for 20+ cycles; ADDI with rt=r0 -> r0 still reads 0.
